// File: rtl/comparador_serial_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared types and constants for the bit-serial magnitude comparator.
//   state_t  : controller states (IDLE, RUN, DONE)
//   EQ/GT/LT : 2-bit internal encoding of the running compare decision
//   idx_width: width of the bit-index counter for a given operand width
// -----------------------------------------------------------------------------
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] EQ = 2'b00;
    localparam logic [1:0] GT = 2'b01;
    localparam logic [1:0] LT = 2'b10;

    // Operand widths are at least 2, so this never collapses to zero bits.
    function automatic int idx_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// -----------------------------------------------------------------------------
// comparador_serial_if
// Handshake and operand bundle of the serial comparator.
//   start, a, b, signed_mode : request side (driven by the master)
//   busy, done, eq, gt, lt   : status/result side (driven by the comparator)
// -----------------------------------------------------------------------------
interface comparador_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/comparador_serial_bit.sv
// -----------------------------------------------------------------------------
// comparador_bit
// Purely combinational single-bit compare cell.
//   ai, bi      : the current bit of operand A and B
//   is_msb      : the bit being examined is the sign position
//   signed_mode : operands are two's complement
//   diff        : the two bits differ
//   a_greater   : when diff is set, A is the larger operand
// -----------------------------------------------------------------------------
module comparador_bit (
    input  logic ai,
    input  logic bi,
    input  logic is_msb,
    input  logic signed_mode,
    output logic diff,
    output logic a_greater
);

    // The sign bit carries negative weight, so a 1 there marks the smaller
    // operand; everywhere else a 1 marks the larger one.
    assign diff      = ai ^ bi;
    assign a_greater = (is_msb && signed_mode) ? bi : ai;

endmodule

// File: rtl/comparador_serial.sv
// -----------------------------------------------------------------------------
// comparador_serial
// Bit-serial magnitude comparator, MSB first, unsigned or two's complement,
// with optional early exit on the first differing bit.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : comparador_serial_if slave (start/a/b/signed_mode in,
//           busy/done/eq/gt/lt out, all outputs registered)
// -----------------------------------------------------------------------------
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    comparador_serial_if.slave bus
);

    localparam int IW = idx_width(WIDTH);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             signed_q, signed_d;
    logic             found_q, found_d;
    logic [1:0]       res_q, res_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic             bitDiff;
    logic             bitAGreater;
    logic             isMsb;
    logic             newDiff;
    logic [1:0]       bitRes;
    logic [1:0]       finalRes;

    // Single compare cell, fed with the bit currently selected by idx.
    assign isMsb = (idx_q == IW'(WIDTH - 1));

    comparador_bit uBit (
        .ai          (opA_q[idx_q]),
        .bi          (opB_q[idx_q]),
        .is_msb      (isMsb),
        .signed_mode (signed_q),
        .diff        (bitDiff),
        .a_greater   (bitAGreater)
    );

    // Only the first difference counts; finalRes folds in a difference found
    // on the very edge that leaves RUN.
    assign newDiff  = bitDiff & ~found_q;
    assign bitRes   = bitAGreater ? GT : LT;
    assign finalRes = newDiff ? bitRes : res_q;

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;

    // Next-state logic; idx is tested for zero before any decrement so it
    // never wraps.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        signed_d = signed_q;
        found_d  = found_q;
        res_d    = res_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opA_d    = bus.a;
                    opB_d    = bus.b;
                    signed_d = bus.signed_mode;
                    idx_d    = IW'(WIDTH - 1);
                    found_d  = 1'b0;
                    res_d    = EQ;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (newDiff) begin
                    found_d = 1'b1;
                    res_d   = bitRes;
                end
                if ((idx_q == '0) || ((EARLY_EXIT != 0) && newDiff)) begin
                    state_d = DONE;
                    eq_d    = (finalRes == EQ);
                    gt_d    = (finalRes == GT);
                    lt_d    = (finalRes == LT);
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any compare in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            signed_q <= 1'b0;
            found_q  <= 1'b0;
            res_q    <= EQ;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            signed_q <= signed_d;
            found_q  <= found_d;
            res_q    <= res_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
        end
    end

endmodule

// File: tb/tb_comparador_serial.sv
// -----------------------------------------------------------------------------
// tb_comparador_serial
// Drives three comparators (8-bit constant latency, 8-bit early exit, 2-bit)
// and checks them against an arithmetic reference model every cycle, plus
// hand-computed expectations for the directed cases.
// -----------------------------------------------------------------------------
module tb_comparador_serial;

    logic       clk;
    logic       rst_n;
    logic       start8, sm8, start2, sm2;
    logic [7:0] a8, b8;
    logic [1:0] a2, b2;

    int nChecks = 0;
    int nFails  = 0;

    comparador_serial_if #(.WIDTH(8)) bus0 ();
    comparador_serial_if #(.WIDTH(8)) bus1 ();
    comparador_serial_if #(.WIDTH(2)) bus2 ();

    assign bus0.start = start8;  assign bus0.a = a8;  assign bus0.b = b8;  assign bus0.signed_mode = sm8;
    assign bus1.start = start8;  assign bus1.a = a8;  assign bus1.b = b8;  assign bus1.signed_mode = sm8;
    assign bus2.start = start2;  assign bus2.a = a2;  assign bus2.b = b2;  assign bus2.signed_mode = sm2;

    comparador_serial #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    comparador_serial #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    comparador_serial #(.WIDTH(2), .EARLY_EXIT(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Per-DUT views so the model and checker can loop over all three.
    int   widthOf [3] = '{8, 8, 2};
    int   eeOf    [3] = '{0, 1, 0};
    logic dStart  [3];
    logic [7:0] dA [3];
    logic [7:0] dB [3];
    logic dSm     [3];
    logic obsBusy [3];
    logic obsDone [3];
    logic obsEq   [3];
    logic obsGt   [3];
    logic obsLt   [3];

    assign dStart[0] = start8; assign dA[0] = a8; assign dB[0] = b8; assign dSm[0] = sm8;
    assign dStart[1] = start8; assign dA[1] = a8; assign dB[1] = b8; assign dSm[1] = sm8;
    assign dStart[2] = start2; assign dA[2] = {6'b0, a2}; assign dB[2] = {6'b0, b2}; assign dSm[2] = sm2;

    assign obsBusy[0] = bus0.busy; assign obsDone[0] = bus0.done;
    assign obsEq[0] = bus0.eq; assign obsGt[0] = bus0.gt; assign obsLt[0] = bus0.lt;
    assign obsBusy[1] = bus1.busy; assign obsDone[1] = bus1.done;
    assign obsEq[1] = bus1.eq; assign obsGt[1] = bus1.gt; assign obsLt[1] = bus1.lt;
    assign obsBusy[2] = bus2.busy; assign obsDone[2] = bus2.done;
    assign obsEq[2] = bus2.eq; assign obsGt[2] = bus2.gt; assign obsLt[2] = bus2.lt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compare on integer values: +1 a>b, 0 equal, -1 a<b.
    function automatic int refCmp(input logic [7:0] a, input logic [7:0] b,
                                  input logic sm, input int w);
        int av, bv;
        av = int'(a) & ((1 << w) - 1);
        bv = int'(b) & ((1 << w) - 1);
        if (sm && av >= (1 << (w - 1))) av = av - (1 << w);
        if (sm && bv >= (1 << (w - 1))) bv = bv - (1 << w);
        return (av > bv) ? 1 : ((av < bv) ? -1 : 0);
    endfunction

    // Edges from accept to DONE entry: full width, or up to the highest
    // differing bit when exiting early.
    function automatic int refLat(input logic [7:0] a, input logic [7:0] b,
                                  input int w, input int ee);
        if (ee == 0) return w;
        for (int j = w - 1; j >= 0; j--)
            if (a[j] != b[j]) return w - j;
        return w;
    endfunction

    task automatic checkOutput(input string name, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Transaction-level model: busy for latency+1 cycles, done in the last.
    bit mBusy [3];
    bit mDone [3];
    bit mEq   [3];
    bit mGt   [3];
    bit mLt   [3];
    int mRemain [3];
    int mPend   [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mBusy[i] <= 1'b0; mDone[i] <= 1'b0;
                mEq[i] <= 1'b0; mGt[i] <= 1'b0; mLt[i] <= 1'b0;
                mRemain[i] <= 0; mPend[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (mDone[i]) begin
                    mDone[i] <= 1'b0;
                    mBusy[i] <= 1'b0;
                end else if (mBusy[i]) begin
                    if (mRemain[i] == 1) begin
                        mDone[i] <= 1'b1;
                        mEq[i]   <= (mPend[i] == 0);
                        mGt[i]   <= (mPend[i] == 1);
                        mLt[i]   <= (mPend[i] == -1);
                    end
                    mRemain[i] <= mRemain[i] - 1;
                end else if (dStart[i]) begin
                    mBusy[i]   <= 1'b1;
                    mRemain[i] <= refLat(dA[i], dB[i], widthOf[i], eeOf[i]);
                    mPend[i]   <= refCmp(dA[i], dB[i], dSm[i], widthOf[i]);
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("busy dut%0d", i), int'(obsBusy[i]), int'(mBusy[i]));
            checkOutput($sformatf("done dut%0d", i), int'(obsDone[i]), int'(mDone[i]));
            checkOutput($sformatf("eq dut%0d", i),   int'(obsEq[i]),   int'(mEq[i]));
            checkOutput($sformatf("gt dut%0d", i),   int'(obsGt[i]),   int'(mGt[i]));
            checkOutput($sformatf("lt dut%0d", i),   int'(obsLt[i]),   int'(mLt[i]));
            if (obsDone[i])
                checkOutput($sformatf("onehot dut%0d", i),
                            int'(obsEq[i]) + int'(obsGt[i]) + int'(obsLt[i]), 1);
        end
    end

    // Issue one start pulse, accepted on the posedge between two negedges.
    task automatic applyStimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                                 input logic sm);
        @(negedge clk);
        if (sel == 0) begin
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        end else begin
            a2 = a[1:0]; b2 = b[1:0]; sm2 = sm; start2 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
    endtask

    // Observe a fixed 21-sample window starting at the negedge after the
    // accepting edge; optionally pulse start or scramble operands inside it.
    int nDone   [2];
    int doneCnt [2];
    int busyCnt [2];

    task automatic runWait(input int pulseAt, input int toggleAt);
        for (int i = 0; i < 2; i++) begin
            nDone[i] = -1; doneCnt[i] = 0; busyCnt[i] = 0;
        end
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (obsDone[i]) begin
                    doneCnt[i]++;
                    if (nDone[i] < 0) nDone[i] = c;
                end
                if (obsBusy[i]) busyCnt[i]++;
            end
            if (c == pulseAt) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
            end
            if (c == pulseAt + 1) start8 = 1'b0;
            if (c == toggleAt) begin
                a8 = 8'h00; b8 = 8'hFF;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", int'(bus0.busy), 0);
        checkOutput("reset eq",   int'(bus0.eq),   0);
        rst_n = 1'b1;

        // Equal operands: full latency on both variants.
        applyStimulus(0, 8'hA5, 8'hA5, 1'b0);
        runWait(-1, -1);
        checkOutput("A5 latency ee0", nDone[0], 8);
        checkOutput("A5 latency ee1", nDone[1], 8);
        checkOutput("A5 busy cycles", busyCnt[0], 9);
        checkOutput("A5 eq", int'(bus0.eq), 1);
        checkOutput("A5 gt", int'(bus0.gt), 0);
        checkOutput("A5 lt", int'(bus0.lt), 0);

        // MSB difference: unsigned says greater, early exit after one bit.
        applyStimulus(0, 8'h80, 8'h7F, 1'b0);
        runWait(-1, -1);
        checkOutput("80v7F u gt", int'(bus0.gt), 1);
        checkOutput("80v7F u latency ee0", nDone[0], 8);
        checkOutput("80v7F u latency ee1", nDone[1], 1);
        checkOutput("80v7F u busy ee1", busyCnt[1], 2);
        checkOutput("80v7F u gt ee1", int'(bus1.gt), 1);

        // Same operands in two's complement: -128 < 127.
        applyStimulus(0, 8'h80, 8'h7F, 1'b1);
        runWait(-1, -1);
        checkOutput("80v7F s lt", int'(bus0.lt), 1);
        checkOutput("80v7F s lt ee1", int'(bus1.lt), 1);

        // LSB difference, and a start pulse during the DONE cycle.
        applyStimulus(0, 8'h10, 8'h11, 1'b0);
        runWait(8, -1);
        checkOutput("10v11 latency ee1", nDone[1], 8);
        checkOutput("10v11 lt ee1", int'(bus1.lt), 1);
        checkOutput("10v11 done pulses ee0", doneCnt[0], 1);
        checkOutput("10v11 done pulses ee1", doneCnt[1], 1);

        // Operands scrambled during RUN must not matter.
        applyStimulus(0, 8'h03, 8'h02, 1'b0);
        runWait(-1, 2);
        checkOutput("03v02 gt ee0", int'(bus0.gt), 1);
        checkOutput("03v02 gt ee1", int'(bus1.gt), 1);

        // Asynchronous reset in the middle of a compare.
        applyStimulus(0, 8'hA5, 8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", int'(bus0.busy), 0);
        checkOutput("midreset done", int'(bus0.done), 0);
        checkOutput("midreset gt",   int'(bus0.gt),   0);
        checkOutput("midreset eq",   int'(bus0.eq),   0);
        checkOutput("midreset lt",   int'(bus0.lt),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runWait(-1, -1);
        checkOutput("no done after reset", doneCnt[0], 0);
        applyStimulus(0, 8'hA5, 8'h5A, 1'b0);
        runWait(-1, -1);
        checkOutput("post-reset latency ee0", nDone[0], 8);
        checkOutput("post-reset latency ee1", nDone[1], 1);
        checkOutput("post-reset gt", int'(bus0.gt), 1);

        // 2-bit exhaustive sweep in both modes.
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    applyStimulus(1, 8'(a), 8'(b), 1'(sm));
                    repeat (2) @(negedge clk);
                    checkOutput("w2 done at latency", int'(bus2.done), 1);
                    if (a == 2 && b == 1)
                        checkOutput("w2 2v1", int'({bus2.eq, bus2.gt, bus2.lt}),
                                    (sm == 1) ? 1 : 2);
                    @(negedge clk);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
